// File: rtl/nror1w_dup_ctrl.sv
// nR-or-1W duplicated-bank front end: write broadcast, per-port read copies.
// Define NROR1W_DUP_INIT_EN to zero every copy with a row sweep after reset.
module nror1w_dup_ctrl #(
  parameter int WIDTH      = 32,
  parameter int NUMRDPT    = 2,
  parameter int NUMADDR    = 8192,
  parameter int BITADDR    = 13,
  parameter int NUMVBNK    = 8,
  parameter int BITVBNK    = 3,
  parameter int NUMVROW    = 1024,
  parameter int BITVROW    = 10,
  parameter int SRAM_DELAY = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 ready,
  input  logic                                 refr,
  input  logic [NUMRDPT-1:0]                   read,
  input  logic [NUMRDPT*BITADDR-1:0]           rd_adr,
  input  logic                                 write,
  input  logic [BITADDR-1:0]                   wr_adr,
  input  logic [WIDTH-1:0]                     din,
  output logic [NUMRDPT-1:0]                   rd_vld,
  output logic [NUMRDPT*WIDTH-1:0]             rd_dout,
  output logic                                 acc_err,
  output logic                                 t1_refr,
  output logic [NUMRDPT*NUMVBNK-1:0]           t1_readA,
  output logic [NUMRDPT*NUMVBNK-1:0]           t1_writeA,
  output logic [NUMRDPT*NUMVBNK*BITVROW-1:0]   t1_addrA,
  output logic [NUMRDPT*NUMVBNK*WIDTH-1:0]     t1_dinA,
  input  logic [NUMRDPT*NUMVBNK*WIDTH-1:0]     t1_doutA
);

  localparam int NUMSLOT = NUMRDPT * NUMVBNK;

  typedef enum logic {S_INIT, S_READY} state_t;
  state_t state;

  logic               sweep;
  logic [BITVROW-1:0] sweep_row;

`ifdef NROR1W_DUP_INIT_EN
  logic [BITVROW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == BITVROW'(NUMVROW - 1)) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  assign sweep     = (state == S_INIT);
  assign sweep_row = cnt;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      ready <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          state <= S_READY;
          ready <= 1'b1;
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  assign sweep     = 1'b0;
  assign sweep_row = '0;
`endif

  logic [NUMRDPT-1:0][BITADDR-1:0] rd_a;
  logic [NUMRDPT-1:0][BITVBNK-1:0] rd_bnk;
  logic [NUMRDPT-1:0][BITVROW-1:0] rd_row;
  logic [BITVBNK-1:0]              wr_bnk;
  logic [BITVROW-1:0]              wr_row;
  logic [NUMRDPT:0]                adr_ok;

  assign rd_a   = rd_adr;
  assign wr_bnk = wr_adr[BITVROW +: BITVBNK];
  assign wr_row = wr_adr[BITVROW-1:0];

  for (genvar p = 0; p < NUMRDPT; p++) begin : g_split
    assign rd_bnk[p] = rd_a[p][BITVROW +: BITVBNK];
    assign rd_row[p] = rd_a[p][BITVROW-1:0];
  end

  // Range check only exists when the address field can exceed the array.
  if (NUMADDR < 2**BITADDR) begin : g_rng
    for (genvar p = 0; p < NUMRDPT; p++) begin : g_p
      assign adr_ok[p] = rd_a[p] < BITADDR'(NUMADDR);
    end
    assign adr_ok[NUMRDPT] = wr_adr < BITADDR'(NUMADDR);
  end else begin : g_full
    assign adr_ok = '1;
  end

  logic               acc_ok;
  logic               wr_ok;
  logic [NUMRDPT-1:0] rd_ok;
  logic               drop;

  assign acc_ok = ready & ~refr;
  assign wr_ok  = write & acc_ok & adr_ok[NUMRDPT];
  assign rd_ok  = read & {NUMRDPT{acc_ok & ~write}}
                & adr_ok[NUMRDPT-1:0];
  assign drop   = (write & ~wr_ok) | (|(read & ~rd_ok));

  logic [NUMSLOT-1:0]              rd_nxt;
  logic [NUMSLOT-1:0]              wr_nxt;
  logic [NUMSLOT-1:0][BITVROW-1:0] addr_nxt;
  logic [NUMSLOT-1:0][WIDTH-1:0]   din_nxt;

  always_comb begin
    rd_nxt   = '0;
    wr_nxt   = '0;
    addr_nxt = '0;
    din_nxt  = '0;
    if (sweep) begin
      wr_nxt = '1;
      for (int s = 0; s < NUMSLOT; s++) addr_nxt[s] = sweep_row;
    end else begin
      for (int p = 0; p < NUMRDPT; p++) begin
        if (wr_ok) begin
          wr_nxt[NUMRDPT*int'(wr_bnk)+p]   = 1'b1;
          addr_nxt[NUMRDPT*int'(wr_bnk)+p] = wr_row;
          din_nxt[NUMRDPT*int'(wr_bnk)+p]  = din;
        end
        if (rd_ok[p]) begin
          rd_nxt[NUMRDPT*int'(rd_bnk[p])+p]   = 1'b1;
          addr_nxt[NUMRDPT*int'(rd_bnk[p])+p] = rd_row[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t1_readA  <= '0;
      t1_writeA <= '0;
      t1_addrA  <= '0;
      t1_dinA   <= '0;
      t1_refr   <= 1'b0;
      acc_err   <= 1'b0;
    end else begin
      t1_readA  <= rd_nxt;
      t1_writeA <= wr_nxt;
      t1_addrA  <= addr_nxt;
      t1_dinA   <= din_nxt;
      t1_refr   <= refr;
      acc_err   <= drop;
    end
  end

  logic [NUMRDPT-1:0]              pv [SRAM_DELAY+1];
  logic [NUMRDPT-1:0][BITVBNK-1:0] pb [SRAM_DELAY+1];
  logic [NUMSLOT-1:0][WIDTH-1:0]   t1_dout;
  logic [NUMRDPT-1:0][WIDTH-1:0]   dout_sel;

  assign t1_dout = t1_doutA;

  always_comb begin
    dout_sel = '0;
    for (int p = 0; p < NUMRDPT; p++) begin
      if (pv[SRAM_DELAY][p])
        dout_sel[p] = t1_dout[NUMRDPT*int'(pb[SRAM_DELAY][p])+p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= SRAM_DELAY; i++) begin
        pv[i] <= '0;
        pb[i] <= '0;
      end
      rd_vld  <= '0;
      rd_dout <= '0;
    end else begin
      pv[0] <= rd_ok;
      pb[0] <= rd_bnk;
      for (int i = 1; i <= SRAM_DELAY; i++) begin
        pv[i] <= pv[i-1];
        pb[i] <= pb[i-1];
      end
      rd_vld  <= pv[SRAM_DELAY];
      rd_dout <= dout_sel;
    end
  end

endmodule

// File: tb/tb_nror1w_dup_ctrl.sv
// Bench for nror1w_dup_ctrl: random traffic against a logical-memory model
// plus literal checks; follows NROR1W_DUP_INIT_EN for the init behaviour.
module tb_nror1w_dup_ctrl;

  localparam int W  = 32;
  localparam int NP = 2;
  localparam int NA = 64;
  localparam int BA = 6;
  localparam int NB = 8;
  localparam int BB = 3;
  localparam int NR = 8;
  localparam int BR = 3;
  localparam int SD = 2;
  localparam int NS = NP * NB;
`ifdef NROR1W_DUP_INIT_EN
  localparam bit INIT_EN = 1'b1;
  localparam int RDY     = NR;
`else
  localparam bit INIT_EN = 1'b0;
  localparam int RDY     = 1;
`endif

  typedef logic [511:0] v_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              refr = 1'b0;
  logic [NP-1:0]     read = '0;
  logic [NP*BA-1:0]  rd_adr = '0;
  logic              write = 1'b0;
  logic [BA-1:0]     wr_adr = '0;
  logic [W-1:0]      din = '0;
  logic              ready, acc_err, t1_refr;
  logic [NP-1:0]     rd_vld;
  logic [NP*W-1:0]   rd_dout;
  logic [NS-1:0]     t1_readA, t1_writeA;
  logic [NS*BR-1:0]  t1_addrA;
  logic [NS*W-1:0]   t1_dinA, t1_doutA;

  nror1w_dup_ctrl #(
    .WIDTH(W), .NUMRDPT(NP), .NUMADDR(NA), .BITADDR(BA),
    .NUMVBNK(NB), .BITVBNK(BB), .NUMVROW(NR), .BITVROW(BR),
    .SRAM_DELAY(SD)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .refr(refr),
    .read(read), .rd_adr(rd_adr), .write(write),
    .wr_adr(wr_adr), .din(din), .rd_vld(rd_vld),
    .rd_dout(rd_dout), .acc_err(acc_err), .t1_refr(t1_refr),
    .t1_readA(t1_readA), .t1_writeA(t1_writeA),
    .t1_addrA(t1_addrA), .t1_dinA(t1_dinA),
    .t1_doutA(t1_doutA)
  );

  // Second instance with a wider address field to reach the range check.
  logic              write2 = 1'b0;
  logic [6:0]        wa2 = '0;
  logic              ready2, acc2, refr2o;
  logic [NP-1:0]     vld2;
  logic [NP*W-1:0]   dout2;
  logic [NS-1:0]     rdA2, wrA2;
  logic [NS*BR-1:0]  addr2;
  logic [NS*W-1:0]   dinA2;

  nror1w_dup_ctrl #(
    .WIDTH(W), .NUMRDPT(NP), .NUMADDR(NA), .BITADDR(7),
    .NUMVBNK(NB), .BITVBNK(BB), .NUMVROW(NR), .BITVROW(BR),
    .SRAM_DELAY(SD)
  ) dut2 (
    .clk(clk), .rst(rst), .ready(ready2), .refr(1'b0),
    .read(2'b00), .rd_adr(14'd0), .write(write2),
    .wr_adr(wa2), .din(din), .rd_vld(vld2),
    .rd_dout(dout2), .acc_err(acc2), .t1_refr(refr2o),
    .t1_readA(rdA2), .t1_writeA(wrA2),
    .t1_addrA(addr2), .t1_dinA(dinA2),
    .t1_doutA({NS*W{1'b0}})
  );

  logic [W-1:0] bmem [NS][NR];
  logic [W-1:0] st1 [NS];
  logic [W-1:0] st2 [NS];
  bit           binit = 1'b0;

  // Bank copies: SD-cycle read latency, junk on unread slots.
  always @(posedge clk) begin
    if (rst && !binit) begin
      binit <= 1'b1;
      for (int s = 0; s < NS; s++)
        for (int r = 0; r < NR; r++)
          bmem[s][r] <= INIT_EN ? W'($urandom) : '0;
    end
    for (int s = 0; s < NS; s++) begin
      if (t1_writeA[s])
        bmem[s][t1_addrA[s*BR +: BR]] <= t1_dinA[s*W +: W];
      st1[s] <= t1_readA[s] ? bmem[s][t1_addrA[s*BR +: BR]]
                            : (32'hDEAD0000 | 32'(s));
      st2[s] <= st1[s];
    end
  end

  always_comb begin
    t1_doutA = '0;
    for (int s = 0; s < NS; s++) t1_doutA[s*W +: W] = st2[s];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input v_t act, input v_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [W-1:0]    mem [NA] = '{default: '0};
  logic [NP-1:0]   pv [8];
  logic [W-1:0]    pd [8][NP];
  int              c = 0;
  int              T = 0;
  bit              started = 1'b0;
  logic            exp_ready, exp_acc, exp_refr;
  logic [NS-1:0]   exp_wr, exp_rd;
  logic [NS*BR-1:0] exp_addr;
  logic [NS*W-1:0] exp_din;
  logic [NP-1:0]   exp_vld;
  logic [NP*W-1:0] exp_dout;

  // Logical model: ready after RDY cycles, reads see all earlier writes.
  task automatic model_step();
    int a, b, s;
    bit drop, rdy, okw;
    exp_wr = '0; exp_rd = '0; exp_addr = '0; exp_din = '0;
    exp_acc = 1'b0; exp_refr = 1'b0;
    if (rst) begin
      started = 1'b1;
      c = 0;
      for (int i = 0; i < 8; i++) begin
        pv[i] = '0;
        for (int p = 0; p < NP; p++) pd[i][p] = '0;
      end
    end else begin
      drop = 1'b0;
      if (INIT_EN && c < NR) begin
        exp_wr = '1;
        for (int k = 0; k < NS; k++) exp_addr[k*BR +: BR] = BR'(c);
        if (c == NR - 1)
          for (int k = 0; k < NA; k++) mem[k] = '0;
      end
      rdy = (c >= RDY);
      okw = write && rdy && !refr;
      if (write && !okw) drop = 1'b1;
      if (okw) begin
        b = int'(wr_adr) / NR;
        for (int p = 0; p < NP; p++) begin
          s = b * NP + p;
          exp_wr[s] = 1'b1;
          exp_addr[s*BR +: BR] = BR'(int'(wr_adr) % NR);
          exp_din[s*W +: W] = din;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (read[p]) begin
          a = int'(rd_adr[p*BA +: BA]);
          if (rdy && !refr && !write) begin
            s = (a / NR) * NP + p;
            exp_rd[s] = 1'b1;
            exp_addr[s*BR +: BR] = BR'(a % NR);
            pv[(T+SD+2)%8][p] = 1'b1;
            pd[(T+SD+2)%8][p] = mem[a];
          end else begin
            drop = 1'b1;
          end
        end
      end
      if (okw) mem[int'(wr_adr)] = din;
      exp_acc  = drop;
      exp_refr = refr;
      c++;
    end
    T++;
    exp_ready = !rst && (c >= RDY);
    exp_vld = pv[T%8];
    for (int p = 0; p < NP; p++) exp_dout[p*W +: W] = pd[T%8][p];
    pv[T%8] = '0;
    for (int p = 0; p < NP; p++) pd[T%8][p] = '0;
  endtask

  task automatic cmp_cycle();
    if (!started) return;
    chk("ready", v_t'(ready), v_t'(exp_ready));
    chk("acc_err", v_t'(acc_err), v_t'(exp_acc));
    chk("t1_refr", v_t'(t1_refr), v_t'(exp_refr));
    chk("t1_writeA", v_t'(t1_writeA), v_t'(exp_wr));
    chk("t1_readA", v_t'(t1_readA), v_t'(exp_rd));
    chk("t1_addrA", v_t'(t1_addrA), v_t'(exp_addr));
    chk("t1_dinA", v_t'(t1_dinA), v_t'(exp_din));
    chk("rd_vld", v_t'(rd_vld), v_t'(exp_vld));
    chk("rd_dout", v_t'(rd_dout), v_t'(exp_dout));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 40 && !ready; i++) tick();
    chk(nm, v_t'(ready), v_t'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [BA-1:0] last_wa;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", v_t'(ready), v_t'(0));
    chk("rst_vld", v_t'(rd_vld), v_t'(0));
    chk("rst_dout", v_t'(rd_dout), v_t'(0));
    chk("rst_wrA", v_t'(t1_writeA), v_t'(0));
    for (int k = 0; k < NR; k++) begin
      if (k == 0) begin
        read = 2'b01;
        rd_adr[5:0] = 6'h13;
      end
      tick();
      read = '0;
      chk("init_wrA", v_t'(t1_writeA),
          v_t'(INIT_EN ? 16'hFFFF : 16'h0000));
      chk("init_row0", v_t'(t1_addrA[BR-1:0]),
          v_t'(INIT_EN ? k : 0));
      chk("init_row15", v_t'(t1_addrA[15*BR +: BR]),
          v_t'(INIT_EN ? k : 0));
      chk("init_ready", v_t'(ready), v_t'(k + 1 >= RDY));
      if (k == 0) begin
        chk("notrdy_acc", v_t'(acc_err), v_t'(1));
        chk("notrdy_rdA", v_t'(t1_readA), v_t'(0));
      end
    end

    write = 1'b1; wr_adr = 6'h13; din = 32'hA5A5A5A5;
    tick();
    write = 1'b0;
    chk("bc_wrA", v_t'(t1_writeA), v_t'(16'h0030));
    chk("bc_addr4", v_t'(t1_addrA[4*BR +: BR]), v_t'(3));
    chk("bc_addr5", v_t'(t1_addrA[5*BR +: BR]), v_t'(3));
    chk("bc_din4", v_t'(t1_dinA[4*W +: W]), v_t'(32'hA5A5A5A5));
    chk("bc_din5", v_t'(t1_dinA[5*W +: W]), v_t'(32'hA5A5A5A5));

    read = 2'b11; rd_adr = {6'h13, 6'h13};
    tick();
    read = '0;
    chk("dr_rdA", v_t'(t1_readA), v_t'(16'h0030));
    tick();
    tick();
    chk("dr_vld_early", v_t'(rd_vld), v_t'(0));
    tick();
    chk("dr_vld", v_t'(rd_vld), v_t'(2'b11));
    chk("dr_dout", v_t'(rd_dout), v_t'({2{32'hA5A5A5A5}}));

    write = 1'b1; wr_adr = 6'h05; din = 32'h12345678;
    read = 2'b01; rd_adr[5:0] = 6'h05;
    tick();
    write = 1'b0; read = '0;
    chk("wr_rd_acc", v_t'(acc_err), v_t'(1));
    chk("wr_rd_rdA", v_t'(t1_readA), v_t'(0));
    chk("wr_rd_wrA", v_t'(t1_writeA), v_t'(16'h0003));
    refr = 1'b1; read = 2'b10; rd_adr[11:6] = 6'h13;
    tick();
    refr = 1'b0; read = '0;
    chk("refr_acc", v_t'(acc_err), v_t'(1));
    chk("refr_t1", v_t'(t1_refr), v_t'(1));
    chk("refr_rdA", v_t'(t1_readA), v_t'(0));
    tick();
    chk("acc_clear", v_t'(acc_err), v_t'(0));

    write2 = 1'b1; wa2 = 7'd64;
    tick();
    chk("oor_acc", v_t'(acc2), v_t'(1));
    chk("oor_wrA", v_t'(wrA2), v_t'(0));
    wa2 = 7'd63;
    tick();
    write2 = 1'b0;
    chk("inr_acc", v_t'(acc2), v_t'(0));
    chk("inr_wrA", v_t'(wrA2), v_t'(16'hC000));

    for (int r = 0; r < NR; r++) begin
      write = 1'b1; wr_adr = 6'(56 + r); din = 32'h70000000 + r;
      tick();
    end
    write = 1'b0;
    for (int i = 0; i < 12; i++) begin
      read = (i < 8) ? 2'b01 : 2'b00;
      rd_adr[5:0] = 6'(56 + i);
      tick();
      chk("stream_vld", v_t'(rd_vld[0]),
          v_t'(i + 1 >= 4 && i + 1 < 12));
      chk("stream_dat", v_t'(rd_dout[W-1:0]),
          v_t'((i + 1 >= 4 && i + 1 < 12) ? 32'h70000000 + i - 3 : 0));
    end
    read = '0;

    read = 2'b01; rd_adr[5:0] = 6'h13;
    tick();
    read = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmr_vld3", v_t'(rd_vld), v_t'(0));
    tick();
    chk("rmr_vld4", v_t'(rd_vld), v_t'(0));
    chk("rmr_sweep", v_t'(t1_writeA),
        v_t'(INIT_EN ? 16'hFFFF : 16'h0000));
    chk("rmr_row", v_t'(t1_addrA[BR-1:0]), v_t'(0));
    wait_ready("rmr_ready");

    last_wa = '0;
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      refr  = ($urandom_range(0, 15) == 0);
      write = ($urandom_range(0, 3) == 0);
      wr_adr = BA'($urandom);
      din   = $urandom;
      for (int p = 0; p < NP; p++) begin
        read[p] = 1'($urandom_range(0, 1));
        rd_adr[p*BA +: BA] = ($urandom_range(0, 2) == 0)
                           ? last_wa : BA'($urandom);
      end
      if (write) last_wa = wr_adr;
      tick();
    end
    rst = 1'b0; refr = 1'b0; write = 1'b0; read = '0;
    for (int i = 0; i < 12; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nror1w_dup_ctrl.md
# nror1w_dup_ctrl

Front-end controller for the duplicated nR-or-1W bank array. It accepts NUMRDPT read ports and one write port. Each write is broadcast to every read-port copy of the target bank, and each read port is steered to its private copy. The block also handles post-reset initialization, refresh blocking and read-data return. It sits between the user access interface and the t1_* physical bank bus.

## Interface
- WIDTH, 32, data width
- NUMRDPT, 2, read ports (= copies per bank)
- NUMADDR, 8192, logical depth; must equal NUMVBNK*NUMVROW
- BITADDR, 13, address width
- NUMVBNK, 8, banks (power of 2)
- BITVBNK, 3, bank index width
- NUMVROW, 1024, rows per bank (power of 2)
- BITVROW, 10, row index width
- SRAM_DELAY, 2, bank read latency in cycles (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- ready  out  1  controller accepting accesses
- refr  in  1  refresh request
- read  in  NUMRDPT  per-port read request
- rd_adr  in  NUMRDPT*BITADDR  per-port read address
- write  in  1  write request
- wr_adr  in  BITADDR  write address
- din  in  WIDTH  write data
- rd_vld  out  NUMRDPT  read data valid
- rd_dout  out  NUMRDPT*WIDTH  read data
- acc_err  out  1  one-cycle pulse: request dropped
- t1_refr  out  1  registered refresh to banks
- t1_readA  out  NUMRDPT*NUMVBNK  copy read enables; slot s = NUMRDPT*bank+port
- t1_writeA  out  NUMRDPT*NUMVBNK  copy write enables
- t1_addrA  out  NUMRDPT*NUMVBNK*BITVROW  per-slot row
- t1_dinA  out  NUMRDPT*NUMVBNK*WIDTH  per-slot write data
- t1_doutA  in  NUMRDPT*NUMVBNK*WIDTH  per-slot read data

## Operation
- Address split: bank = adr[BITADDR-1:BITVROW], row = adr[BITVROW-1:0].
- FSM states:
  - INIT: rst forces INIT and row counter to 0.
  - READY: reached from INIT per Configuration.
  - rst asserted in any state returns to INIT. It also clears the command registers, the read pipeline, rd_vld and acc_err.
- INIT sweep: one row per cycle, written to all NUMRDPT*NUMVBNK slots, addr = counter, din = 0. Reads are not issued during the sweep.
- A request is dropped, and acc_err pulses for one cycle, if any of the following hold:
  - it arrives while !ready;
  - it arrives with refr high;
  - its address is ≥ NUMADDR;
  - it is a read arriving with write high. The write proceeds and all reads that cycle are dropped.
- Write (accepted): for bank b, set t1_writeA for all slots NUMRDPT*b+p. Each of those slots gets row and din.
- Read port p (accepted): set t1_readA[NUMRDPT*b+p] with row. Ports never share a slot, so all ports can hit the same bank in the same cycle.
- Unused slots: enables 0; addr and din 0.
- Read pipeline: per-port valid plus bank index, depth SRAM_DELAY+1. At the exit stage, the selected t1_doutA slot is registered into rd_dout.
- Outputs when idle: rd_dout is 0 whenever rd_vld is 0.
- t1_refr is refr delayed one cycle.
- Reset values: ready=0, rd_vld=0, rd_dout=0, acc_err=0, t1_refr=0, all t1_* outputs 0.

## Timing
- Cycle 0 is the first cycle with rst low.
- Request sampled in cycle N → t1 command driven in cycle N+1 (registered).
- Read data: rd_vld and rd_dout are driven in cycle N+SRAM_DELAY+2.
- acc_err is driven in cycle N+1.
- Back-to-back accesses every cycle are allowed; the pipeline has no stalls.
- Write followed by a read of the same address in the next cycle returns the new data. Ordering is preserved by the banks.

## Configuration
- NROR1W_DUP_INIT_EN defined:
  - INIT sweeps rows 0..NUMVROW-1, driven on t1 in cycles 1..NUMVROW.
  - State goes READY at the end of cycle NUMVROW-1, so ready is high from cycle NUMVROW.
  - Reset mid-sweep restarts the sweep at row 0.
- Not defined: no sweep and no INIT writes; ready is high from cycle 1.

## Test plan
Bench configuration for all scenarios: NUMRDPT=2, NUMVBNK=8, NUMVROW=8, BITVROW=3, BITADDR=6, NUMADDR=64, SRAM_DELAY=2, macro defined.
- Init sweep:
  - Deassert rst → t1_writeA=16'hFFFF with addr k in cycle k+1, for k=0..7; ready rises in cycle 8.
  - Rerun without the macro → ready rises in cycle 1 and no writes occur.
- Broadcast write:
  - Write 0x13 (bank 2, row 3) with din 32'hA5A5A5A5 in cycle N.
  - Expected in N+1: t1_writeA=16'h0030; slots 4 and 5 carry addr 3 and that din.
- Dual read, same bank:
  - Both ports read 0x13 in cycle M.
  - Expected: t1_readA=16'h0030 in M+1; rd_vld=2'b11 in M+4 with both rd_dout = 32'hA5A5A5A5 (bank model returns written data).
- Drop cases, each giving acc_err=1 in the next cycle and no t1 enables:
  - write and read[0] together → only the write is issued;
  - read with refr=1 → t1_refr=1 next cycle;
  - read while !ready;
  - wr_adr=64 with BITADDR widened to 7.
- Reset mid-read:
  - Read in cycle M, rst in M+2 → rd_vld stays 0 through M+4.
  - With the macro, the sweep restarts at row 0.
- Streaming:
  - Port 0 reads rows 0..7 of bank 7 on consecutive cycles.
  - Expected: 8 consecutive rd_vld pulses starting 4 cycles later, in order.
